// File: rtl/npc_dmem_responder.sv
// Data-port memory responder for the NPC core: one request in flight, fixed latency, byte-lane alignment.
// Optional address range checking is enabled by defining MEM_RANGE_CHECK_EN.
module npc_dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        wen_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, commit;
  logic [31:0] c_addr, c_wdata;
  logic        c_wen;
  logic [3:0]  c_wmask;
  logic [31:0] offs;
  logic [AW-1:0] c_idx;
  logic [1:0]  c_off;
  logic        c_oob;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data, rd_shifted;

  assign accept    = req_valid && (state_q == StIdle);
  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Leave WAIT on the edge that takes cnt to 0; with LATENCY==1 the accept edge is the commit edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // At the accept edge the request is only on the ports; later it comes from the latches.
  always_comb begin
    c_addr     = (state_q == StIdle) ? req_addr  : addr_q;
    c_wdata    = (state_q == StIdle) ? req_wdata : wdata_q;
    c_wen      = (state_q == StIdle) ? req_wen   : wen_q;
    c_wmask    = (state_q == StIdle) ? req_wmask : wmask_q;
    offs       = c_addr - BASE_ADDR;
    c_idx      = offs[AW+1:2];
    c_off      = c_addr[1:0];
    lane_mask  = c_wmask << c_off;
    lane_data  = c_wdata << {c_off, 3'b000};
    rd_shifted = mem[c_idx] >> {c_off, 3'b000};
`ifdef MEM_RANGE_CHECK_EN
    c_oob      = (c_addr < BASE_ADDR) || ({1'b0, offs} >= (33'(DEPTH_WORDS) << 2));
`else
    c_oob      = 1'b0;
`endif
  end

  logic unused_offs;
  assign unused_offs = ^{offs[31:AW+2], offs[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wen_q   <= 1'b0;
      wmask_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wen_q   <= req_wen;
        wmask_q <= req_wmask;
      end
      if (commit) begin
        err_q   <= c_oob;
        rdata_q <= (c_wen || c_oob) ? 32'd0 : rd_shifted;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && c_wen && !c_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem[c_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_npc_dmem_responder.sv
// Bench for npc_dmem_responder: a LATENCY=1 and a LATENCY=3 instance against a byte-level memory model.
module tb_npc_dmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  reset, req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];
  logic [3:0]  req_wmask [2];

  int nvec = 0;
  int nerr = 0;

  npc_dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wmask(req_wmask[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  npc_dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // Reference memory: one byte per entry, keyed by instance and wrapped byte offset.
  logic [7:0] rmem [int unsigned];

  function automatic int unsigned key(input int d, input logic [31:0] a);
    return (int'(d) << 28) | ((a - BASE) % (4 * DEPTH));
  endfunction

  function automatic logic m_oob(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
    return (a < BASE) || ((a - BASE) >= 4 * DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_store(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] wm);
    int off = int'(a % 4);
    if (m_oob(a)) return;
    for (int i = 0; i < 4; i++)
      if (wm[i] && (off + i) < 4) rmem[key(d, a + 32'(i))] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] m_load(input int d, input logic [31:0] a);
    logic [31:0] r = 32'd0;
    int off = int'(a % 4);
    if (m_oob(a)) return 32'd0;
    for (int i = 0; i < 4 - off; i++)
      if (rmem.exists(key(d, a + 32'(i)))) r[8*i +: 8] = rmem[key(d, a + 32'(i))];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One full transaction; lat counts cycles from the accept cycle to the first rsp_valid cycle.
  task automatic xact(input int d, input logic wen, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] wm, output logic [31:0] rd, output logic er,
                      output int lat);
    int n = 0;
    req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = a;
    req_wdata[d] = wd;   req_wmask[d] = wm;
    while (!req_ready[d] && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic wen, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] wm, output logic [31:0] rd);
    logic [31:0] exp;
    logic er;
    int lat;
    exp = wen ? 32'd0 : m_load(d, a);
    xact(d, wen, a, wd, wm, rd, er, lat);
    if (wen) m_store(d, a, wd, wm);
    chk($sformatf("rdata d%0d %s %h", d, wen ? "st" : "ld", a), rd, exp);
    chk($sformatf("err d%0d %h", d, a), 32'(er), 32'(m_oob(a)));
    chk($sformatf("latency d%0d", d), 32'(lat), (d == 0) ? 32'd1 : 32'd3);
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, held;
    tbl[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000};
    tbl[1] = '{1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h8000_0013, 32'h0000_00AA, 4'b0001, 32'h0000_0000};
    tbl[3] = '{1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'hAAAD_BEEF};
    tbl[4] = '{1'b0, 32'h8000_0013, 32'h0,         4'b0000, 32'h0000_00AA};
    tbl[5] = '{1'b1, 32'h8000_0012, 32'h0000_1234, 4'b0011, 32'h0000_0000};
    tbl[6] = '{1'b0, 32'h8000_0010, 32'h0,         4'b0000, 32'h1234_BEEF};
    tbl[7] = '{1'b0, 32'h8000_0012, 32'h0,         4'b0000, 32'h0000_1234};

    reset = 2'b11; req_valid = 2'b00; req_wen = 2'b00; rsp_ready = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; req_wmask[d] = 4'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset req_ready d%0d", d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("reset rsp_valid d%0d", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("reset rsp_rdata d%0d", d), rsp_rdata[d], 32'd0);
      chk($sformatf("reset rsp_err d%0d", d), 32'(rsp_err[d]), 32'd0);
    end
    reset = 2'b00;
    @(posedge clk); #1;

    // Directed byte-lane table on the LATENCY=1 instance.
    for (int i = 0; i < 8; i++) begin
      run(0, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, rd);
      chk($sformatf("table row %0d", i), rd, tbl[i].exp);
    end

    // Response held while backpressured; requests presented meanwhile must be ignored.
    run(0, 1'b1, 32'h8000_0014, 32'h0102_0304, 4'b1111, rd);
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0010;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    held = m_load(0, 32'h8000_0010);
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = (i % 2 == 0); req_wen[0] = 1'b1; req_addr[0] = 32'h8000_0014;
      req_wdata[0] = 32'hFFFF_FFFF; req_wmask[0] = 4'b1111;
      @(posedge clk); #1;
      chk($sformatf("hold rsp_valid %0d", i), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("hold rsp_rdata %0d", i), rsp_rdata[0], held);
      chk($sformatf("hold req_ready %0d", i), 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    chk("release rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("release req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    chk("no stray accept", 32'(rsp_valid[0]), 32'd0);
    run(0, 1'b0, 32'h8000_0014, 32'd0, 4'd0, rd);

    // Reset during WAIT on the LATENCY=3 instance aborts the store.
    run(1, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1111, rd);
    run(1, 1'b0, 32'h8000_0020, 32'd0, 4'd0, rd);
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020;
    req_wdata[1] = 32'h5555_5555; req_wmask[1] = 4'b1111;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("wait req_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    reset[1] = 1'b1;
    @(posedge clk); #1;
    chk("midreset req_ready", 32'(req_ready[1]), 32'd1);
    chk("midreset rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midreset rsp_rdata", rsp_rdata[1], 32'd0);
    chk("midreset rsp_err", 32'(rsp_err[1]), 32'd0);
    reset[1] = 1'b0;
    @(posedge clk); #1;
    run(1, 1'b0, 32'h8000_0020, 32'd0, 4'd0, rd);
    chk("aborted store invisible", rd, 32'h1122_3344);

    // Range behaviour.
`ifdef MEM_RANGE_CHECK_EN
    run(0, 1'b0, 32'h7FFF_FFFC, 32'd0, 4'd0, rd);
    run(0, 1'b1, BASE + 4 * DEPTH, 32'hCAFE_F00D, 4'b1111, rd);
    run(0, 1'b0, 32'h8000_0000, 32'd0, 4'd0, rd);
`else
    run(0, 1'b1, 32'h8000_0000, 32'h0BAD_0BAD, 4'b1111, rd);
    run(0, 1'b1, BASE + 4 * DEPTH, 32'hCAFE_F00D, 4'b1111, rd);
    run(0, 1'b0, 32'h8000_0000, 32'd0, 4'd0, rd);
    chk("alias at base", rd, 32'hCAFE_F00D);
`endif

    // Random traffic over a small window on both instances.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        run(d, 1'b1, BASE + 32'(4 * w), $urandom, 4'b1111, rd);
    for (int k = 0; k < 60; k++) begin
      run(k % 2, 1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 63)), $urandom,
          4'($urandom_range(0, 15)), rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
